ram_arb: RTL
============

RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter AW, default 2, RAM address width in bits.
REQ-002 Parameter DW, default 4, RAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1; held high until the matching ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; held stable while req is high.
REQ-007 adr0 / adr1  input  AW  access address; held stable while req is high.
REQ-008 din0 / din1  input  DW  write data; held stable while req is high.
REQ-009 ack0 / ack1  output  1  one-cycle pulse marking completion of the granted access.
REQ-010 rdata0 / rdata1  output  DW  read result; valid while ack is high and held until the next read by the same requester.
REQ-011 clr  input  1  request to rerun the RAM clear sequence; honoured only in IDLE.
REQ-012 busy  output  1  high while in CLR.
REQ-013 ram_adr  output  AW  address to the RAM.
REQ-014 ram_din  output  DW  write data to the RAM.
REQ-015 ram_we  output  1  RAM write enable; the RAM writes on the rising clk edge when ram_we=1.
REQ-016 ram_dout  input  DW  RAM asynchronous read data for ram_adr.

Function
REQ-017 The FSM SHALL have exactly four states: CLR, IDLE, ACC, ACK.
REQ-018 In CLR, a 2^AW-cycle counter SHALL drive ram_adr = 0,1,...,2^AW-1, with ram_din=0 and ram_we=1; after the last address the next state is IDLE.
REQ-019 In IDLE, clr=1 SHALL go to CLR (counter restarts at 0) and take priority over any request.
REQ-020 In IDLE with clr=0 and exactly one request, that requester SHALL be latched as winner, and the next state is ACC.
REQ-021 In IDLE with both requests, the winner SHALL be the requester not served last (round-robin).
REQ-022 After reset the round-robin pointer SHALL favour requester 0.
REQ-023 In IDLE with no request and clr=0, the FSM SHALL remain in IDLE.
REQ-024 In ACC, ram_adr/ram_din/ram_we SHALL equal the winner's adr/din/we.
REQ-025 In ACC on a read, ram_dout SHALL be registered into the winner's rdata.
REQ-026 On a write, rdata SHALL be unchanged; the RAM is written at the edge ending ACC; the next state is ACK.
REQ-027 In ACK, the winner's ack SHALL be 1 for exactly one cycle, the last-served pointer updates to the winner, and the next state is IDLE.
REQ-028 Latency: a request seen in IDLE at cycle N SHALL produce ack at cycle N+2; minimum spacing between accesses is 3 cycles.
REQ-029 In IDLE, ACK and CLR (outside its drive), ram_we SHALL be 0 and ram_adr, ram_din SHALL be 0.
REQ-030 The losing requester SHALL stay pending without ack and SHALL be served in the next IDLE.
REQ-031 req, we, adr and din changes outside IDLE/ACC SHALL have no effect; the requester deasserts req on seeing ack.
REQ-032 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-033 rst_n=0 at any edge, including mid-ACC or mid-CLR, SHALL force state CLR, clear counter=0, ack0=ack1=0, rdata0=rdata1=0, pointer favouring requester 0.
REQ-034 An access interrupted by reset SHALL receive no ack; its RAM write is suppressed if reset is sampled at the ACC edge.
REQ-035 The first 2^AW cycles after rst_n rises SHALL clear every RAM word to 0.

Verification
REQ-036 Reset, then idle -> busy=1 for 4 cycles with ram_adr 0,1,2,3, ram_we=1, ram_din=0; then busy=0 and all RAM words read 0.
REQ-037 req0 writes 1,2,4,8 to addresses 0..3, then reads addresses 0..3 -> rdata0 = 1,2,4,8 with ack0 at cycle N+2 of each request.
REQ-038 req0 and req1 both raised in the same cycle after reset -> ack0 first, then ack1 three cycles later; a repeat collision -> ack1 first.
REQ-039 req1 writes 4'hA to address 2 while req0 reads address 2 in the next slot -> rdata0=4'hA; rdata1 unchanged.
REQ-040 rst_n low during ACC of a req0 write -> no ack0, target word=0 after the clear sequence, busy=1.
REQ-041 clr=1 together with req1 in IDLE -> CLR runs first (4 cycles), then req1 is served; RAM contents are zero before the access.

Source files
------------

// File: rtl/ram_arb.sv
// ram_arb: two-requester round-robin arbiter in front of a single-port RAM.
// After reset (or on request in IDLE) it first zeroes every RAM word, then
// serves one access at a time in three cycles: IDLE (arbitrate), ACC (drive
// the RAM, capture read data), ACK (one-cycle ack pulse to the winner).
//
// Ports
//   i_clk                 single clock, rising edge
//   i_rst_n               synchronous active-low reset
//   i_req0/1, i_we0/1     request and write-enable per requester
//   i_adr0/1, i_din0/1    address and write data per requester
//   o_ack0/1              one-cycle completion pulse per requester
//   o_rdata0/1            last read result per requester
//   i_clr                 rerun the clear sequence (taken only in IDLE)
//   o_busy                clear sequence in progress
//   o_ram_adr/din/we      RAM address, write data, write enable
//   i_ram_dout            RAM asynchronous read data for o_ram_adr
//
// State | meaning
// ------+-----------------------------------------------------------
// CLR   | walk r_cnt over every address, writing 0
// IDLE  | arbitrate between pending requests or accept a clear request
// ACC   | drive the winner's access onto the RAM, capture read data
// ACK   | pulse the winner's ack, record it as last served
module ram_arb #(
    parameter int AW = 2,
    parameter int DW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_adr0,
    input  logic [AW-1:0] i_adr1,
    input  logic [DW-1:0] i_din0,
    input  logic [DW-1:0] i_din1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    input  logic          i_clr,
    output logic          o_busy,
    output logic [AW-1:0] o_ram_adr,
    output logic [DW-1:0] o_ram_din,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_dout
);

    localparam logic [1:0] S_CLR  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_win;
    logic          r_last;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_pick;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_adr;
    logic [DW-1:0] w_sel_din;
    logic [AW-1:0] w_ram_adr;
    logic [DW-1:0] w_ram_din;
    logic          w_ram_we;

    // With both requests pending the one not served last wins; with a single
    // request that requester wins (i_req1 alone selects 1, i_req0 alone 0).
    always_comb begin
        w_pick = i_req1;
        if (i_req0 && i_req1) begin
            w_pick = ~r_last;
        end
    end

    assign w_sel_we  = r_win ? i_we1  : i_we0;
    assign w_sel_adr = r_win ? i_adr1 : i_adr0;
    assign w_sel_din = r_win ? i_din1 : i_din0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_CLR;
            r_cnt    <= '0;
            r_win    <= 1'b0;
            r_last   <= 1'b1;       // last served = 1, so requester 0 is favoured
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                S_CLR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (i_clr) begin
                        r_state <= S_CLR;
                        r_cnt   <= '0;
                    end else if (i_req0 || i_req1) begin
                        r_win   <= w_pick;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (!w_sel_we) begin
                        if (r_win) begin
                            r_rdata1 <= i_ram_dout;
                        end else begin
                            r_rdata0 <= i_ram_dout;
                        end
                    end
                    r_state <= S_ACK;
                end
                default: begin
                    r_last  <= r_win;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_ram_adr = '0;
        w_ram_din = '0;
        w_ram_we  = 1'b0;
        case (r_state)
            S_CLR: begin
                w_ram_adr = r_cnt;
                w_ram_we  = 1'b1;
            end
            S_ACC: begin
                w_ram_adr = w_sel_adr;
                w_ram_din = w_sel_din;
                w_ram_we  = w_sel_we;
            end
            default: begin
                w_ram_adr = '0;
            end
        endcase
    end

    // Reset is synchronous, so the RAM would still see the write strobe on the
    // edge where reset is sampled; gating with i_rst_n drops that write.
    assign o_ram_we  = w_ram_we & i_rst_n;
    assign o_ram_adr = w_ram_adr;
    assign o_ram_din = w_ram_din;

    assign o_ack0   = (r_state == S_ACK) && !r_win;
    assign o_ack1   = (r_state == S_ACK) &&  r_win;
    assign o_busy   = (r_state == S_CLR);
    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;

endmodule
